// File: rtl/seq_shift_pkg.sv
// seq_shift_pkg
//   Shared encodings for the iterative shift unit: operation select codes
//   and FSM state encoding, plus a reserved-mode decode helper.
//   Build option: SEQ_SHIFT_FLAGS_EN (see seq_shift_unit) needs nothing here.
package seq_shift_pkg;

  localparam logic [2:0] MODE_LSL  = 3'b000;
  localparam logic [2:0] MODE_LSR  = 3'b001;
  localparam logic [2:0] MODE_ASR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_NORM = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // 110/111 have no operation: they complete immediately with the operand.
  function automatic logic is_reserved(input logic [2:0] m);
    logic r;
    case (m)
      MODE_LSL, MODE_LSR, MODE_ASR,
      MODE_ROL, MODE_ROR, MODE_NORM: r = 1'b0;
      default:                       r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// shift_step
//   Combinational single-position shift of i_value for the selected mode.
//   Ports:
//     i_value   in  WIDTH  current working value
//     i_mode    in  3      operation select (seq_shift_pkg MODE_*)
//     o_next    out WIDTH  value after one position
//     o_out_bit out 1      bit that left the word (wrapped bit for rotates)
//   NORM steps exactly like LSL; the top decides how many steps to take.
//   Reserved modes pass the value through with o_out_bit = 0.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [2:0]       i_mode,
  output logic [WIDTH-1:0] o_next,
  output logic             o_out_bit
);

  // One-position shift/rotate per mode.
  always_comb begin
    o_next    = i_value;
    o_out_bit = 1'b0;
    case (i_mode)
      MODE_LSL, MODE_NORM: begin
        o_next    = {i_value[WIDTH-2:0], 1'b0};
        o_out_bit = i_value[WIDTH-1];
      end
      MODE_LSR: begin
        o_next    = {1'b0, i_value[WIDTH-1:1]};
        o_out_bit = i_value[0];
      end
      MODE_ASR: begin
        o_next    = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
        o_out_bit = i_value[0];
      end
      MODE_ROL: begin
        o_next    = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
        o_out_bit = i_value[WIDTH-1];
      end
      MODE_ROR: begin
        o_next    = {i_value[0], i_value[WIDTH-1:1]};
        o_out_bit = i_value[0];
      end
      default: begin
        o_next    = i_value;
        o_out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// seq_shift_unit
//   Multi-cycle shift/rotate/normalise resource: one bit position per clock,
//   start/done handshake, IDLE -> SHIFT -> DONE -> IDLE.
//   Ports:
//     clk     in  1      rising-edge clock
//     reset   in  1      asynchronous active-high reset
//     start   in  1      request, accepted when ready=1
//     mode    in  3      operation (seq_shift_pkg MODE_*)
//     operand in  WIDTH  data captured on accept
//     amount  in  AMT_W  shift count captured on accept (unused for NORM)
//     ready   out 1      high in IDLE only
//     done    out 1      one-cycle pulse, result/count valid
//     result  out WIDTH  shifted value, held until the next completion
//     count   out CNT_W  positions shifted (saturating)
//     carry   out 1      [SEQ_SHIFT_FLAGS_EN] last bit shifted out
//     zero    out 1      [SEQ_SHIFT_FLAGS_EN] result == 0
//   Build option: define SEQ_SHIFT_FLAGS_EN to add the carry/zero outputs.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int AMT_W = 5,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef SEQ_SHIFT_FLAGS_EN
  output logic             carry,
  output logic             zero,
`endif
  output logic [CNT_W-1:0] count
);

  // Iteration counter must hold both a full amount and WIDTH (NORM of zero).
  localparam int N_W = (AMT_W > CNT_W) ? AMT_W : CNT_W;
  localparam logic [N_W-1:0] CNT_MAX = N_W'((2 ** CNT_W) - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_val, w_val_nxt;
  logic [2:0]       r_mode, w_mode_nxt;
  logic [N_W-1:0]   r_remain, w_remain_nxt;
  logic [N_W-1:0]   r_n, w_n_nxt;
  logic [WIDTH-1:0] r_result, w_res_nxt;
  logic [CNT_W-1:0] r_count, w_cnt_nxt;
  logic [N_W-1:0]   w_cnt_raw;
  logic             r_ready, r_done;
  logic             w_upd;
  logic [N_W-1:0]   w_lzc;
  logic [N_W-1:0]   w_n_acc;
  logic             w_reserved;
  logic [WIDTH-1:0] w_step_next;
`ifdef SEQ_SHIFT_FLAGS_EN
  logic             w_step_bit;
  logic             r_carry, w_carry_nxt;
  logic             r_zero, w_zero_nxt;
`else
  logic             w_step_bit_unused;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_value   (r_val),
    .i_mode    (r_mode),
    .o_next    (w_step_next),
`ifdef SEQ_SHIFT_FLAGS_EN
    .o_out_bit (w_step_bit)
`else
    .o_out_bit (w_step_bit_unused)
`endif
  );

  // Leading-zero count of the incoming operand; the highest set bit wins
  // because it is visited last. All-zero operand yields WIDTH.
  always_comb begin
    w_lzc = N_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      w_lzc = operand[i] ? N_W'(WIDTH - 1 - i) : w_lzc;
    end
  end

  assign w_reserved = is_reserved(mode);
  assign w_n_acc    = (mode == MODE_NORM) ? w_lzc : N_W'(amount);

  // Next-state and datapath updates; w_upd marks the edge entering DONE.
  always_comb begin
    w_state_nxt  = r_state;
    w_val_nxt    = r_val;
    w_mode_nxt   = r_mode;
    w_remain_nxt = r_remain;
    w_n_nxt      = r_n;
    w_upd        = 1'b0;
    w_res_nxt    = r_result;
    w_cnt_raw    = {N_W{1'b0}};
`ifdef SEQ_SHIFT_FLAGS_EN
    w_carry_nxt  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_val_nxt    = operand;
          w_mode_nxt   = mode;
          w_n_nxt      = w_n_acc;
          w_remain_nxt = w_n_acc;
          // Nothing to iterate: zero amount, reserved op, or NORM of zero
          // (the only case where w_n_acc reaches WIDTH for NORM).
          if (w_reserved || (w_n_acc == {N_W{1'b0}}) ||
              ((mode == MODE_NORM) && (operand == {WIDTH{1'b0}}))) begin
            w_state_nxt = ST_DONE;
            w_upd       = 1'b1;
            w_res_nxt   = operand;
            w_cnt_raw   = w_reserved ? {N_W{1'b0}} : w_n_acc;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_val_nxt    = w_step_next;
        w_remain_nxt = r_remain - N_W'(1);
        if (r_remain == N_W'(1)) begin
          w_state_nxt = ST_DONE;
          w_upd       = 1'b1;
          w_res_nxt   = w_step_next;
          w_cnt_raw   = r_n;
`ifdef SEQ_SHIFT_FLAGS_EN
          w_carry_nxt = w_step_bit;
`endif
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_cnt_nxt = CNT_W'((w_cnt_raw > CNT_MAX) ? CNT_MAX : w_cnt_raw);
`ifdef SEQ_SHIFT_FLAGS_EN
  assign w_zero_nxt = (w_res_nxt == {WIDTH{1'b0}});
`endif

  // State, working registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_val    <= {WIDTH{1'b0}};
      r_mode   <= 3'b000;
      r_remain <= {N_W{1'b0}};
      r_n      <= {N_W{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
`ifdef SEQ_SHIFT_FLAGS_EN
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_val    <= w_val_nxt;
      r_mode   <= w_mode_nxt;
      r_remain <= w_remain_nxt;
      r_n      <= w_n_nxt;
      r_ready  <= (w_state_nxt == ST_IDLE);
      r_done   <= (w_state_nxt == ST_DONE);
      if (w_upd) begin
        r_result <= w_res_nxt;
        r_count  <= w_cnt_nxt;
`ifdef SEQ_SHIFT_FLAGS_EN
        r_carry  <= w_carry_nxt;
        r_zero   <= w_zero_nxt;
`endif
      end else begin
        r_result <= r_result;
        r_count  <= r_count;
      end
    end
  end

  assign ready  = r_ready;
  assign done   = r_done;
  assign result = r_result;
  assign count  = r_count;
`ifdef SEQ_SHIFT_FLAGS_EN
  assign carry  = r_carry;
  assign zero   = r_zero;
`endif

endmodule
